// File: rtl/ct_fadd_lzd_onehot_pipe.sv
// ---------------------------------------------------------------------------
// ct_fadd_lzd_onehot_pipe
//
// Two-stage valid/ready leading-one detector for the fadd normalization path.
// It scans a 54-bit mantissa and returns two results: the MSB-aligned one-hot
// leading-one vector and the binary left-shift count that feeds the one-hot
// shift selector.
//
//   Stage 1 : splits the word into GW-bit groups, numbered from the top.
//             For each group it registers an any-flag, the local one-hot of
//             the group's highest set bit, and that bit's local position.
//   Stage 2 : selects the first flagged group from the top. It places the
//             group's local one-hot into the full-width vector and forms
//             shift = GW*g + local position.
//
// Optional build macro CT_FADD_LZD_SHIFT_LIMIT_EN enables the denormal
// exponent clamp. The shift is clamped to min(in_max_shift, DW-1), and
// out_limited flags a clamped result. Without the macro, in_max_shift is
// ignored and out_limited is tied to 0.
//
// Ports:
//   forever_cpuclk  clock
//   cpurst          synchronous active-high reset
//   pipe_flush      synchronous flush of all in-flight entries
//   in_vld/in_rdy   input handshake; in_rdy is combinational
//   in_data         mantissa to scan
//   in_max_shift    shift limit (clamp build only)
//   out_vld/out_rdy output handshake
//   out_data        in_data passed through unchanged
//   out_onehot      one-hot leading one; bit k set means shift = DW-1-k
//   out_shift       left-shift count
//   out_zero        in_data was all zero
//   out_limited     result was clamped by in_max_shift
// ---------------------------------------------------------------------------
module ct_fadd_lzd_onehot_pipe #(
  parameter int DW = 54,  // fixed at 54; must be a multiple of GW
  parameter int GW = 6
) (
  input  logic          forever_cpuclk,
  input  logic          cpurst,
  input  logic          pipe_flush,
  input  logic          in_vld,
  output logic          in_rdy,
  input  logic [DW-1:0] in_data,
  input  logic [5:0]    in_max_shift,
  output logic          out_vld,
  input  logic          out_rdy,
  output logic [DW-1:0] out_data,
  output logic [DW-1:0] out_onehot,
  output logic [5:0]    out_shift,
  output logic          out_zero,
  output logic          out_limited
);

  localparam int NG = DW / GW;

  // ---------------- pipeline control ----------------
  logic s1_vld_q, out_vld_q;
  logic s2_adv, s1_adv, in_acc, s2_load;

  assign s2_adv  = !out_vld_q || out_rdy;
  assign s1_adv  = !s1_vld_q || s2_adv;
  assign in_rdy  = s1_adv && !pipe_flush && !cpurst;
  assign in_acc  = in_vld && in_rdy;
  assign s2_load = s2_adv && s1_vld_q && !pipe_flush;

  // ---------------- stage 1: per-group partial detect ----------------
  logic [NG-1:0] g_any_d;
  logic [GW-1:0] g_loh_d [NG];
  logic [2:0]    g_pos_d [NG];

  always_comb begin
    logic [GW-1:0] grp;
    for (int g = 0; g < NG; g++) begin
      grp        = in_data[DW-1-g*GW -: GW];
      g_any_d[g] = |grp;
      // NOTE: every combinational output gets a default before the
      // conditional updates, so no path leaves it unassigned (no latch).
      g_loh_d[g] = '0;
      g_pos_d[g] = '0;
      // Scan upward so that the highest set bit writes last and wins.
      for (int b = 0; b < GW; b++) begin
        if (grp[b]) begin
          g_loh_d[g]    = '0;
          g_loh_d[g][b] = 1'b1;
          g_pos_d[g]    = 3'(GW - 1 - b);
        end
      end
    end
  end

  logic [NG-1:0] s1_any_q;
  logic [GW-1:0] s1_loh_q [NG];
  logic [2:0]    s1_pos_q [NG];
  logic [DW-1:0] s1_data_q;

  // NOTE: sequential state is always written with non-blocking (<=)
  // assignments, so every register samples pre-edge values.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      s1_vld_q  <= 1'b0;
      out_vld_q <= 1'b0;
    end else if (pipe_flush) begin
      s1_vld_q  <= 1'b0;
      out_vld_q <= 1'b0;
    end else begin
      if (s1_adv) s1_vld_q  <= in_acc;
      if (s2_adv) out_vld_q <= s1_vld_q;
    end
  end

  // NOTE: the stage-1 payload registers are deliberately left without a
  // reset. The valid bit qualifies them, and they load only on accept.
  always_ff @(posedge forever_cpuclk) begin
    if (in_acc) begin
      s1_any_q  <= g_any_d;
      s1_loh_q  <= g_loh_d;
      s1_pos_q  <= g_pos_d;
      s1_data_q <= in_data;
    end
  end

`ifdef CT_FADD_LZD_SHIFT_LIMIT_EN
  logic [5:0] s1_max_q;
  always_ff @(posedge forever_cpuclk) begin
    if (in_acc) s1_max_q <= in_max_shift;
  end
`else
  // The shift limit has no function in this build.
  logic unused_max_shift;
  assign unused_max_shift = ^in_max_shift;
`endif

  // ---------------- stage 2: group select and final encode ----------------
  logic          found;
  logic [DW-1:0] raw_oh;
  logic [5:0]    raw_shift;
  logic [DW-1:0] onehot_d;
  logic [5:0]    shift_d;
  logic          limited_d;

  always_comb begin
    found     = 1'b0;
    raw_oh    = '0;
    raw_shift = '0;
    for (int g = 0; g < NG; g++) begin
      if (!found && s1_any_q[g]) begin
        found                       = 1'b1;
        raw_oh[DW-1-g*GW -: GW]     = s1_loh_q[g];
        raw_shift                   = 6'(g * GW) + 6'(s1_pos_q[g]);
      end
    end
  end

`ifdef CT_FADD_LZD_SHIFT_LIMIT_EN
  logic [5:0] lim;
  always_comb begin
    lim       = (s1_max_q > 6'(DW - 1)) ? 6'(DW - 1) : s1_max_q;
    onehot_d  = raw_oh;
    shift_d   = raw_shift;
    limited_d = 1'b0;
    if (found && (raw_shift > lim)) begin
      onehot_d  = DW'(1) << (6'(DW - 1) - lim);
      shift_d   = lim;
      limited_d = 1'b1;
    end
  end
`else
  assign onehot_d  = raw_oh;
  assign shift_d   = raw_shift;
  assign limited_d = 1'b0;
`endif

  logic [DW-1:0] out_data_q, out_onehot_q;
  logic [5:0]    out_shift_q;
  logic          out_zero_q, out_limited_q;

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      out_data_q    <= '0;
      out_onehot_q  <= '0;
      out_shift_q   <= '0;
      out_zero_q    <= 1'b0;
      out_limited_q <= 1'b0;
    end else if (s2_load) begin
      out_data_q    <= s1_data_q;
      out_onehot_q  <= onehot_d;
      out_shift_q   <= shift_d;
      out_zero_q    <= !found;
      out_limited_q <= limited_d;
    end
  end

  assign out_vld     = out_vld_q;
  assign out_data    = out_data_q;
  assign out_onehot  = out_onehot_q;
  assign out_shift   = out_shift_q;
  assign out_zero    = out_zero_q;
  assign out_limited = out_limited_q;

endmodule

// File: tb/tb_ct_fadd_lzd_onehot_pipe.sv
// ---------------------------------------------------------------------------
// tb_ct_fadd_lzd_onehot_pipe
//
// Directed bench for ct_fadd_lzd_onehot_pipe. The tests cover:
//   - reset state
//   - single operands at the top, bottom, and group-boundary bit positions
//   - all-zero data
//   - backpressure with in-order drain
//   - flush
//   - reset in mid-operation
//   - the shift-limit vectors
// Expected values for the shift-limit vectors follow whichever build
// (CT_FADD_LZD_SHIFT_LIMIT_EN defined or not) is being compiled.
// ---------------------------------------------------------------------------
module tb_ct_fadd_lzd_onehot_pipe;

  logic        forever_cpuclk;
  logic        cpurst;
  logic        pipe_flush;
  logic        in_vld;
  logic        in_rdy;
  logic [53:0] in_data;
  logic [5:0]  in_max_shift;
  logic        out_vld;
  logic        out_rdy;
  logic [53:0] out_data;
  logic [53:0] out_onehot;
  logic [5:0]  out_shift;
  logic        out_zero;
  logic        out_limited;

  int n_checks = 0;
  int n_errors = 0;

  ct_fadd_lzd_onehot_pipe #(.DW(54), .GW(6)) dut (
    .forever_cpuclk (forever_cpuclk),
    .cpurst         (cpurst),
    .pipe_flush     (pipe_flush),
    .in_vld         (in_vld),
    .in_rdy         (in_rdy),
    .in_data        (in_data),
    .in_max_shift   (in_max_shift),
    .out_vld        (out_vld),
    .out_rdy        (out_rdy),
    .out_data       (out_data),
    .out_onehot     (out_onehot),
    .out_shift      (out_shift),
    .out_zero       (out_zero),
    .out_limited    (out_limited)
  );

  initial begin
    forever_cpuclk = 1'b0;
    forever #5 forever_cpuclk = ~forever_cpuclk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one operand for a single cycle. It is accepted at the next edge,
  // and the result is checked two edges after acceptance.
  task automatic run_one(input string tag, input logic [53:0] d, input logic [5:0] ms,
                         input logic [53:0] exp_oh, input logic [5:0] exp_sh,
                         input logic exp_zero, input logic exp_lim);
    @(negedge forever_cpuclk);
    in_data      = d;
    in_max_shift = ms;
    in_vld       = 1'b1;
    #1;
    check({tag, "_in_rdy"}, in_rdy, 1);
    @(negedge forever_cpuclk);
    in_vld = 1'b0;
    @(negedge forever_cpuclk);
    check({tag, "_vld"},     out_vld, 1);
    check({tag, "_data"},    out_data, d);
    check({tag, "_onehot"},  out_onehot, exp_oh);
    check({tag, "_shift"},   out_shift, exp_sh);
    check({tag, "_zero"},    out_zero, exp_zero);
    check({tag, "_limited"}, out_limited, exp_lim);
  endtask

  logic [53:0] bp_ops [4];
  logic [53:0] held_data;
  logic [5:0]  held_shift;
  int          tx, rx, stall_left;
  bit          stall_started;

  initial begin
    cpurst       = 1'b1;
    pipe_flush   = 1'b0;
    in_vld       = 1'b0;
    in_data      = '0;
    in_max_shift = 6'd63;
    out_rdy      = 1'b1;

    // ---- reset state ----
    repeat (2) @(negedge forever_cpuclk);
    check("rst_in_rdy",   in_rdy, 0);
    check("rst_out_vld",  out_vld, 0);
    check("rst_data",     out_data, 0);
    check("rst_onehot",   out_onehot, 0);
    check("rst_shift",    out_shift, 0);
    check("rst_zero",     out_zero, 0);
    check("rst_limited",  out_limited, 0);
    cpurst = 1'b0;
    #1;
    check("rel_in_rdy", in_rdy, 1);

    // ---- single operands ----
    run_one("top",  54'h20_0000_0000_0000, 6'd63, 54'h20_0000_0000_0000, 6'd0,  1'b0, 1'b0);
    run_one("bot",  54'h1,                 6'd63, 54'h1,                 6'd53, 1'b0, 1'b0);
    run_one("grp1", 54'h00_8000_0000_0000, 6'd63, 54'h00_8000_0000_0000, 6'd6,  1'b0, 1'b0);
    run_one("ones", 54'h3F_FFFF_FFFF_FFFF, 6'd63, 54'h20_0000_0000_0000, 6'd0,  1'b0, 1'b0);
    run_one("g1lo", 54'h00_0400_0000_00FF, 6'd63, 54'h00_0400_0000_0000, 6'd11, 1'b0, 1'b0);
    run_one("zero", 54'h0,                 6'd0,  54'h0,                 6'd0,  1'b1, 1'b0);

    // ---- shift limit ----
`ifdef CT_FADD_LZD_SHIFT_LIMIT_EN
    run_one("lim10", 54'h100, 6'd10, 54'h00_0800_0000_0000, 6'd10, 1'b0, 1'b1);
`else
    run_one("lim10", 54'h100, 6'd10, 54'h100, 6'd45, 1'b0, 1'b0);
`endif
    run_one("lim63", 54'h100, 6'd63, 54'h100, 6'd45, 1'b0, 1'b0);
    run_one("lim53", 54'h1,   6'd53, 54'h1,   6'd53, 1'b0, 1'b0);

    // ---- backpressure: 4 operands, 4-cycle stall at first result ----
    for (int i = 0; i < 4; i++) bp_ops[i] = 54'(1) << (53 - i);
    @(negedge forever_cpuclk);
    tx = 0; rx = 0; stall_left = 0; stall_started = 0;
    held_data = '0; held_shift = '0;
    for (int cyc = 0; cyc < 40 && rx < 4; cyc++) begin
      if (cyc > 0) @(negedge forever_cpuclk);
      if (out_vld && !stall_started) begin
        stall_started = 1;
        stall_left    = 4;
        held_data     = out_data;
        held_shift    = out_shift;
      end
      out_rdy = (stall_left == 0);
      in_vld  = (tx < 4);
      in_data = (tx < 4) ? bp_ops[tx] : '0;
      in_max_shift = 6'd63;
      #1;
      if (stall_left > 0) begin
        check("bp_in_rdy_low", in_rdy, 0);
        check("bp_vld_held",   out_vld, 1);
        if (stall_left < 4) begin
          check("bp_data_held",  out_data, held_data);
          check("bp_shift_held", out_shift, held_shift);
        end
        stall_left--;
      end
      if (out_vld && out_rdy) begin
        check("bp_data",   out_data, bp_ops[rx]);
        check("bp_onehot", out_onehot, bp_ops[rx]);
        check("bp_shift",  out_shift, rx);
        rx++;
      end
      if (in_vld && in_rdy) tx++;
    end
    check("bp_stalled",  stall_started, 1);
    check("bp_rx_count", rx, 4);
    check("bp_tx_count", tx, 4);
    in_vld  = 1'b0;
    out_rdy = 1'b1;

    // ---- flush with two entries in flight ----
    @(negedge forever_cpuclk);
    in_vld  = 1'b1;
    in_data = 54'h00_0000_0000_0040;   // A: bit 6
    @(negedge forever_cpuclk);
    in_data = 54'h00_0000_0000_0080;   // B: bit 7
    @(negedge forever_cpuclk);
    check("fl_pre_vld", out_vld, 1);
    pipe_flush = 1'b1;
    in_data    = 54'h00_0000_0010_0000; // C: bit 20, shift 33
    #1;
    check("fl_in_rdy", in_rdy, 0);
    @(negedge forever_cpuclk);
    pipe_flush = 1'b0;
    check("fl_out_vld0", out_vld, 0);
    #1;
    check("fl_in_rdy1", in_rdy, 1);
    @(negedge forever_cpuclk);
    in_vld = 1'b0;
    check("fl_out_vld1", out_vld, 0);
    @(negedge forever_cpuclk);
    check("fl_c_vld",    out_vld, 1);
    check("fl_c_data",   out_data, 54'h00_0000_0010_0000);
    check("fl_c_onehot", out_onehot, 54'h00_0000_0010_0000);
    check("fl_c_shift",  out_shift, 33);
    @(negedge forever_cpuclk);
    check("fl_c_once", out_vld, 0);

    // ---- reset with an entry in flight ----
    in_vld  = 1'b1;
    in_data = 54'h00_0000_0000_0100;
    @(negedge forever_cpuclk);
    in_vld = 1'b0;
    cpurst = 1'b1;
    #1;
    check("mr_in_rdy", in_rdy, 0);
    @(negedge forever_cpuclk);
    check("mr_vld",  out_vld, 0);
    check("mr_data", out_data, 0);
    cpurst = 1'b0;
    @(negedge forever_cpuclk);
    check("mr_vld_after", out_vld, 0);
    @(negedge forever_cpuclk);
    check("mr_vld_after2", out_vld, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ct_fadd_lzd_onehot_pipe.md
Name: ct_fadd_lzd_onehot_pipe

Overview:
Pipelined leading-one detector on the encode side of the fadd normalization path. It scans a 54-bit mantissa and produces the MSB-aligned one-hot leading-one vector and its binary left-shift count, ready to drive the one-hot shift selector. The block sits between the adder result register and the normalize-shift stage. It has a 2-stage valid/ready pipeline, so a downstream stall backs up cleanly without dropping operands.

Parameters:
DW, 54, data width; fixed at 54; must be divisible by GW.
GW, 6, group width for the stage-1 partial detect; gives 9 groups.

Ports:
forever_cpuclk  input  1  clock
cpurst  input  1  synchronous active-high reset
pipe_flush  input  1  synchronous flush; clears all in-flight entries
in_vld  input  1  operand valid
in_rdy  output  1  block can accept an operand this cycle
in_data  input  54  mantissa to scan
in_max_shift  input  6  shift limit; used only with the optional feature
out_vld  output  1  result valid
out_rdy  input  1  downstream accepts the result
out_data  output  54  in_data passed through unchanged
out_onehot  output  54  one-hot leading-one vector; bit k set means shift = 53-k
out_shift  output  6  left-shift count, 0..53
out_zero  output  1  in_data was all zero
out_limited  output  1  result was clamped by in_max_shift

Behaviour:
- Handshake rules:
  - Transfer in occurs when in_vld & in_rdy.
  - Transfer out occurs when out_vld & out_rdy.
  - in_vld and in_data must hold until accepted.
- Pipeline control:
  - s2_adv = !out_vld | out_rdy.
  - s1_adv = !s1_vld | s2_adv.
  - in_rdy = s1_adv & !pipe_flush (combinational).
- Latency and throughput:
  - An operand accepted in cycle N gives out_vld in cycle N+2 when there is no stall.
  - Throughput is 1 per cycle.
  - Results leave in order; there is no drop and no duplication.
- Stage 1 (register s1), per group g = 0..8 with g=0 holding bits 53:48:
  - Group-any flag.
  - 6-bit local one-hot of the highest set bit.
  - 3-bit local position.
  - in_data and in_max_shift are registered alongside.
- Stage 2 (output registers):
  - Select the first group, from the top, whose flag is set.
  - out_onehot = that group's local one-hot placed at the group's position.
  - out_shift = 6*g + local position.
- All-zero data: out_onehot = 0, out_shift = 0, out_zero = 1, out_limited = 0.
- Stall: when out_vld & !out_rdy, all output registers hold. s1 holds if it is occupied; s1 may still load if it is empty.
- Flush:
  - pipe_flush clears the s1 valid bit and out_vld in the next cycle.
  - Flush has priority over simultaneous accept or advance; an operand presented that cycle is not accepted.
  - Data registers keep their values; only the valid bits clear.
- Reset:
  - cpurst drives all valid bits and out_data/out_onehot/out_shift/out_zero/out_limited to 0 at the next edge.
  - Reset asserted mid-operation discards in-flight entries.
  - in_rdy is 0 while cpurst is high.
- Data registers load only on advance, to save toggle power.

Optional Feature:
- Macro: CT_FADD_LZD_SHIFT_LIMIT_EN.
- When defined (denormal exponent clamp), stage 2 sets lim = min(in_max_shift, 53). If data is nonzero and the raw shift exceeds lim:
  - out_shift = lim.
  - out_onehot = bit (53-lim) only.
  - out_limited = 1.
  - Otherwise the raw result passes through with out_limited = 0.
- When not defined: in_max_shift is ignored and not registered, out_limited is tied to 0, and the stage-2 clamp logic is absent.

Test Plan:
- Leading one at the top: in_data = 54'h20_0000_0000_0000, out_rdy = 1 → 2 cycles later out_onehot = 54'h20_0000_0000_0000, out_shift = 0, out_zero = 0.
- Leading one at the bottom and group boundary:
  - in_data = 54'h1 → out_onehot = 54'h1, out_shift = 53.
  - in_data = 54'h00_8000_0000_0000 → out_shift = 6, the first bit of group 1.
- Zero input: in_data = 0 → out_zero = 1, out_onehot = 0, out_shift = 0.
- Backpressure:
  - Stimulus: 4 back-to-back operands with shifts 0, 1, 2, 3; out_rdy low for 4 cycles starting when the first result appears.
  - Response: in_rdy falls once s1 and output are both full; out_data/out_shift hold stable while stalled; after out_rdy rises, all 4 results emerge in order with no loss.
- Flush: pipe_flush for 1 cycle with 2 entries in flight → out_vld = 0 next cycle; the following operand produces the correct result 2 cycles after its acceptance.
- Limit (CT_FADD_LZD_SHIFT_LIMIT_EN defined):
  - in_data = 54'h100 (raw shift 45), in_max_shift = 10 → out_onehot = 54'h00_0800_0000_0000, out_shift = 10, out_limited = 1.
  - Same data with in_max_shift = 63 → out_shift = 45, out_limited = 0.
